load_align_unit: RTL

//  Load-data path between the MEM stage and the data bus for RV32/RV64 loads. Accepts one load at a time.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/load_extend.sv | 22 ++
 rtl/load_align_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: load funct3 encodings, load FSM states and legality helpers
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} ld_state_t;
    function automatic logic f3_illegal(input logic [2:0] f3, input int xlen);
        return f3 == 3'b111 || (xlen == 32 && (f3 == F3_LD || f3 == F3_LWU));
    endfunction
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off[1:0] != 2'b00) ||
               (f3[1:0] == 2'b11 && off != 3'b000);
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: shift a (possibly two-beat) load response by the byte offset and sign/zero-extend per funct3
module load_extend import lsu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]          data,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [2:0]                 funct3,
    output logic [XLEN-1:0]            result
);
    logic [XLEN-1:0] sh;
    // bring the addressed byte to bit 0, then extend the field funct3 names
    always_comb begin
        sh = XLEN'(data >> {off, 3'b000});
        result = funct3 == F3_LB  ? XLEN'($signed(sh[7:0])) :
                 funct3 == F3_LH  ? XLEN'($signed(sh[15:0])) :
                 funct3 == F3_LW  ? XLEN'($signed(sh[31:0])) :
                 funct3 == F3_LBU ? XLEN'(sh[7:0]) :
                 funct3 == F3_LHU ? XLEN'(sh[15:0]) :
                 funct3 == F3_LWU ? XLEN'(sh[31:0]) :
                 funct3 == F3_LD  ? sh : '0;
    end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: one-at-a-time load path issuing aligned bus reads and returning extended data; LOAD_MISALIGN_SPLIT_EN splits misaligned loads into two reads
module load_align_unit import lsu_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rsp_data,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              wb_exc
);
    localparam int B  = XLEN / 8;
    localparam int OW = $clog2(B);
    ld_state_t         state;
    logic [OW-1:0]     off;
    logic [2:0]        f3;
    logic [OW-1:0]     req_off;
    logic              req_mis;
    logic              req_bad;
    logic [2*XLEN-1:0] ext_in;
    logic [XLEN-1:0]   ext_out;
    assign req_ready = state == IDLE;
    assign req_off   = req_addr[OW-1:0];
    assign req_mis   = f3_misaligned(req_funct3, 3'(req_off));
`ifdef LOAD_MISALIGN_SPLIT_EN
    logic            mis;
    logic [XLEN-1:0] rsp0;
    assign req_bad = f3_illegal(req_funct3, XLEN);
    assign ext_in  = state == WAIT1 ? {bus_rsp_data, rsp0} : {{XLEN{1'b0}}, bus_rsp_data};
`else
    assign req_bad = f3_illegal(req_funct3, XLEN) || req_mis;
    assign ext_in  = {{XLEN{1'b0}}, bus_rsp_data};
`endif
    load_extend #(.XLEN(XLEN)) u_ext (
        .data   (ext_in),
        .off    (off),
        .funct3 (f3),
        .result (ext_out)
    );
    // load sequencer: accept, issue aligned read(s), collect response(s), hold result until writeback takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            off           <= '0;
            f3            <= '0;
            bus_req_valid <= 1'b0;
            bus_req_addr  <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_tag        <= '0;
            wb_exc        <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            mis           <= 1'b0;
            rsp0          <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    off    <= req_off;
                    f3     <= req_funct3;
                    wb_tag <= req_tag;
`ifdef LOAD_MISALIGN_SPLIT_EN
                    mis    <= req_mis;
`endif
                    if (req_bad) begin
                        state    <= DONE;
                        wb_valid <= 1'b1;
                        wb_exc   <= 1'b1;
                        wb_data  <= '0;
                    end else begin
                        state         <= REQ0;
                        bus_req_valid <= 1'b1;
                        bus_req_addr  <= req_addr & ~ADDR_W'(B - 1);
                    end
                end
                REQ0: if (bus_req_ready) begin
                    bus_req_valid <= 1'b0;
                    state         <= WAIT0;
                end
                WAIT0: if (bus_rsp_valid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
                    if (mis) begin
                        rsp0          <= bus_rsp_data;
                        bus_req_valid <= 1'b1;
                        bus_req_addr  <= bus_req_addr + ADDR_W'(B);
                        state         <= REQ1;
                    end else begin
                        wb_data  <= ext_out;
                        wb_exc   <= 1'b0;
                        wb_valid <= 1'b1;
                        state    <= DONE;
                    end
`else
                    wb_data  <= ext_out;
                    wb_exc   <= 1'b0;
                    wb_valid <= 1'b1;
                    state    <= DONE;
`endif
                end
`ifdef LOAD_MISALIGN_SPLIT_EN
                REQ1: if (bus_req_ready) begin
                    bus_req_valid <= 1'b0;
                    state         <= WAIT1;
                end
                WAIT1: if (bus_rsp_valid) begin
                    wb_data  <= ext_out;
                    wb_exc   <= 1'b0;
                    wb_valid <= 1'b1;
                    state    <= DONE;
                end
`endif
                DONE: if (wb_ready) begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
